accum_counter_param: RTL and testbench

- Parametrised successor to the fixed 32-bit step counter: a WIDTH-bit register advanced each enabled clock by a STEP_W-bit step.
- Adds up/down direction, wrap or saturate overflow mode, synchronous load, programmable limit with crossing detection, and a sticky overflow flag.
- Sits in the datapath as an event or byte accumulator. Firmware or a controlling FSM polls at_limit and tc, and clears ovf.

---
 rtl/accum_counter_param.sv | 100 ++++++++++
 tb/tb_accum_counter_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/accum_counter_param.sv
// ============================================================================
//  Module      : accum_counter_param
//  Description : WIDTH-bit up/down step accumulator with wrap/saturate,
//                load, limit-crossing pulse and sticky overflow flag.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module accum_counter_param #(
    parameter int                WIDTH     = 32,
    parameter int                STEP_W    = 4,
    parameter int                SATURATE  = 0,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic [STEP_W-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             at_limit,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] c_all_ones = '1;

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   w_step_ext;
    logic [WIDTH:0]   w_raw;
    logic             w_flow;
    logic [WIDTH-1:0] w_next;
    logic             w_step_active;
    logic             w_cross;

    // Arithmetic is done one bit wider so the MSB is carry (up) or borrow (down).
    assign w_step_ext    = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign w_raw         = up ? ({1'b0, count_q} + w_step_ext)
                              : ({1'b0, count_q} - w_step_ext);
    assign w_flow        = w_raw[WIDTH];
    assign w_step_active = en && (step != '0);

    always_comb begin
        w_next = w_raw[WIDTH-1:0];
        if ((SATURATE != 0) && w_flow) begin
            w_next = up ? c_all_ones : '0;
        end
    end

    // Crossing is judged on the pre-step count; starting at limit never fires.
    always_comb begin
        if (up) begin
            w_cross = (count_q < limit) && ((w_next >= limit) || w_flow);
        end else begin
            w_cross = (count_q > limit) && ((w_next <= limit) || w_flow);
        end
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q && !clr_flags;
        if (load) begin
            count_d = load_value;
        end else if (w_step_active) begin
            count_d = w_next;
            tc_d    = w_cross;
            if (w_flow) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign ovf      = ovf_q;
    assign at_limit = (count_q == limit);

endmodule

`default_nettype wire

// File: tb/tb_accum_counter_param.sv
// ============================================================================
//  Module      : tb_accum_counter_param
//  Description : Self-checking bench: three counter configurations driven with
//                directed and random stimulus against an integer-math model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_accum_counter_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, up, load, clr_flags;
    logic [3:0]  step;
    logic [31:0] load_value, limit;

    logic [31:0] cnt_a, cnt_b;
    logic [7:0]  cnt_c;
    logic        atl_a, atl_b, atl_c, tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

    accum_counter_param #(.WIDTH(32), .STEP_W(4), .SATURATE(0), .RESET_VAL(32'd0)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .step(step), .load(load),
        .load_value(load_value), .limit(limit), .clr_flags(clr_flags),
        .count(cnt_a), .at_limit(atl_a), .tc(tc_a), .ovf(ovf_a));

    accum_counter_param #(.WIDTH(32), .STEP_W(4), .SATURATE(1), .RESET_VAL(32'd0)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .step(step), .load(load),
        .load_value(load_value), .limit(limit), .clr_flags(clr_flags),
        .count(cnt_b), .at_limit(atl_b), .tc(tc_b), .ovf(ovf_b));

    accum_counter_param #(.WIDTH(8), .STEP_W(4), .SATURATE(1), .RESET_VAL(8'h5A)) u_small (
        .clk(clk), .reset(reset), .en(en), .up(up), .step(step), .load(load),
        .load_value(load_value[7:0]), .limit(limit[7:0]), .clr_flags(clr_flags),
        .count(cnt_c), .at_limit(atl_c), .tc(tc_c), .ovf(ovf_c));

    // Reference model: unbounded integer arithmetic, then range rules applied.
    longint m_cnt [3];
    longint m_max [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFF};
    longint m_rv  [3] = '{0, 0, 64'h5A};
    bit     m_sat [3] = '{1'b0, 1'b1, 1'b1};
    bit     m_tc  [3];
    bit     m_ovf [3];

    int checks = 0;
    int errors = 0;

    task automatic check_value(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            longint lv  = {32'd0, load_value} & m_max[i];
            longint lim = {32'd0, limit} & m_max[i];
            longint raw;
            bit     flow;
            if (!reset) begin
                m_cnt[i] = m_rv[i];
                m_tc[i]  = 1'b0;
                m_ovf[i] = 1'b0;
            end else if (load) begin
                m_cnt[i] = lv;
                m_tc[i]  = 1'b0;
                m_ovf[i] = m_ovf[i] && !clr_flags;
            end else if (en && step != 0) begin
                raw  = up ? m_cnt[i] + longint'(step) : m_cnt[i] - longint'(step);
                flow = (raw < 0) || (raw > m_max[i]);
                m_tc[i] = up ? (m_cnt[i] < lim && raw >= lim)
                             : (m_cnt[i] > lim && raw <= lim);
                if (m_sat[i]) begin
                    m_cnt[i] = (raw < 0) ? 0 : (raw > m_max[i]) ? m_max[i] : raw;
                end else begin
                    m_cnt[i] = raw & m_max[i];
                end
                m_ovf[i] = flow || (m_ovf[i] && !clr_flags);
            end else begin
                m_tc[i]  = 1'b0;
                m_ovf[i] = m_ovf[i] && !clr_flags;
            end
        end
    endtask

    task automatic compare_all();
        longint d_cnt [3];
        bit     d_atl [3];
        bit     d_tc  [3];
        bit     d_ovf [3];
        d_cnt = '{{32'd0, cnt_a}, {32'd0, cnt_b}, {56'd0, cnt_c}};
        d_atl = '{atl_a, atl_b, atl_c};
        d_tc  = '{tc_a, tc_b, tc_c};
        d_ovf = '{ovf_a, ovf_b, ovf_c};
        for (int i = 0; i < 3; i++) begin
            check_value($sformatf("count[%0d]", i), d_cnt[i], m_cnt[i]);
            check_value($sformatf("tc[%0d]", i), longint'(d_tc[i]), longint'(m_tc[i]));
            check_value($sformatf("ovf[%0d]", i), longint'(d_ovf[i]), longint'(m_ovf[i]));
            check_value($sformatf("at_limit[%0d]", i), longint'(d_atl[i]),
                        longint'(m_cnt[i] == ({32'd0, limit} & m_max[i])));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        reset = 1'b1; en = 1'b0; up = 1'b1; step = 4'd0; load = 1'b0; clr_flags = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] v);
        idle();
        load = 1'b1; load_value = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        idle();
        load_value = '0; limit = 32'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
        end

        // Reset held with a pending step, then release.
        reset = 1'b0; en = 1'b1; up = 1'b1; step = 4'hF;
        tick(); tick();
        check_value("reset_count", {32'd0, cnt_a}, 0);
        check_value("reset_ovf_tc", {62'd0, ovf_a, tc_a}, 0);
        reset = 1'b1;
        tick();
        check_value("first_step", {32'd0, cnt_a}, 15);
        tick(); tick();
        check_value("accum_45", {32'd0, cnt_a}, 45);
        reset = 1'b0;
        tick();
        check_value("reset_mid", {32'd0, cnt_a}, 0);

        // Wrap and sticky overflow.
        do_load(32'hFFFF_FFFE);
        en = 1'b1; up = 1'b1; step = 4'd3;
        tick();
        check_value("wrap_count", {32'd0, cnt_a}, 1);
        check_value("wrap_ovf", {63'd0, ovf_a}, 1);
        en = 1'b0;
        tick(); tick(); tick();
        check_value("ovf_sticky", {63'd0, ovf_a}, 1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check_value("ovf_clear", {63'd0, ovf_a}, 0);
        do_load(32'hFFFF_FFFE);
        en = 1'b1; step = 4'd3; clr_flags = 1'b1;
        tick();
        check_value("clr_vs_set", {63'd0, ovf_a}, 1);

        // Saturating underflow onto limit 0.
        idle(); clr_flags = 1'b1; tick();
        limit = 32'd0;
        do_load(32'd2);
        en = 1'b1; up = 1'b0; step = 4'd5;
        tick();
        check_value("sat_zero", {32'd0, cnt_b}, 0);
        check_value("sat_ovf_tc", {62'd0, ovf_b, tc_b}, 3);
        tick();
        check_value("sat_pinned_tc", {32'd0, cnt_b, 31'd0, tc_b}, 0);

        // Limit crossing.
        limit = 32'd10;
        do_load(32'd0);
        en = 1'b1; up = 1'b1; step = 4'd4;
        tick(); tick(); tick();
        check_value("cross_12", {31'd0, cnt_a, tc_a}, {31'd0, 32'd12, 1'b1});
        do_load(32'd0);
        en = 1'b1; up = 1'b1; step = 4'd5;
        tick(); tick();
        check_value("hit_10", {62'd0, atl_a, tc_a}, 3);
        do_load(32'd12);
        en = 1'b1; up = 1'b0; step = 4'd4;
        tick();
        check_value("down_8", {31'd0, cnt_a, tc_a}, {31'd0, 32'd8, 1'b1});

        // Priority.
        idle(); reset = 1'b0; load = 1'b1; load_value = 32'd77;
        tick();
        check_value("reset_over_load", {32'd0, cnt_a}, 0);
        idle(); load = 1'b1; en = 1'b1; step = 4'd7; load_value = 32'd100;
        tick();
        check_value("load_over_en", {32'd0, cnt_a}, 100);

        // Random stress, biased toward range boundaries.
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(63) != 0);
            load      = ($urandom_range(7) == 0);
            en        = ($urandom_range(3) != 0);
            up        = $urandom_range(1);
            step      = 4'($urandom);
            clr_flags = ($urandom_range(15) == 0);
            case ($urandom_range(3))
                0: load_value = 32'hFFFF_FFFF - 32'($urandom_range(20));
                1: load_value = 32'($urandom_range(20));
                2: load_value = 32'($urandom_range(255));
                default: load_value = $urandom;
            endcase
            if ($urandom_range(7) == 0) begin
                limit = $urandom_range(1) ? 32'($urandom_range(255))
                                          : load_value + 32'($urandom_range(31)) - 32'd16;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
